// File: rtl/ucie_ctl_rx_pkg.sv
// Shared definitions for the UCIe control-path receive credit buffer:
// link state request encodings, the receive FSM state type and request decode.
package ucie_ctl_rx_pkg;

    localparam logic [3:0] REQ_NOP       = 4'b0000;
    localparam logic [3:0] REQ_ACTIVE    = 4'b0001;
    localparam logic [3:0] REQ_L1        = 4'b0100;
    localparam logic [3:0] REQ_L2        = 4'b1000;
    localparam logic [3:0] REQ_LINKRESET = 4'b1001;
    localparam logic [3:0] REQ_RETRAIN   = 4'b1011;
    localparam logic [3:0] REQ_DISABLED  = 4'b1100;

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_ERROR  = 2'd3
    } rx_state_e;

    // Requests that take the link out of ACTIVE; unlisted codes behave as NOP.
    function automatic logic is_exit_req(input logic [3:0] req);
        logic hit;
        case (req)
            REQ_L1, REQ_L2, REQ_LINKRESET, REQ_RETRAIN, REQ_DISABLED: hit = 1'b1;
            default:                                                  hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/ucie_ctl_rx_fifo.sv
// First-word-fall-through FIFO holding received flits. Storage is not reset;
// pointers and occupancy clear on reset or flush. Push while full is only
// honoured together with a pop, and pop while empty is ignored.
module ucie_ctl_rx_fifo #(
    parameter int WIDTH = 512,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    import ucie_ctl_rx_pkg::*;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             pop_ok_s;
    logic             push_ok_s;

    assign empty   = (count_r == {CW{1'b0}});
    assign full    = (count_r == CNT_MAX);
    assign count   = count_r;
    assign rd_data = mem_r[rd_ptr_r];

    // Qualify controls so pointers and occupancy can never leave 0..DEPTH.
    always_comb begin
        pop_ok_s  = 1'b0;
        push_ok_s = 1'b0;
        if (pop && !empty) begin
            pop_ok_s = 1'b1;
        end else begin
            pop_ok_s = 1'b0;
        end
        if (push && (!full || pop_ok_s)) begin
            push_ok_s = 1'b1;
        end else begin
            push_ok_s = 1'b0;
        end
    end

    // Flit storage write; contents deliberately left unreset.
    always_ff @(posedge clk) begin
        if (push_ok_s && !flush) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally modulo DEPTH.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/ucie_ctl_rx_credit_buffer.sv
// Receive-side credit buffer: accepts flits from the RDI while ACTIVE,
// presents them to the FDI in order, returns one credit per consumed flit,
// and drops into ERROR (flushing everything) if the sender overruns it.
module ucie_ctl_rx_credit_buffer
    import ucie_ctl_rx_pkg::*;
#(
    parameter int NBYTES = 64,
    parameter int DEPTH  = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [3:0]               i_state_request,
    input  logic [NBYTES*8-1:0]      i_rdi_pl_data,
    input  logic                     i_rdi_pl_valid,
    input  logic                     i_fdi_ready,
    output logic [NBYTES*8-1:0]      o_fdi_data,
    output logic                     o_fdi_data_valid,
    output logic                     o_credit_return,
    output logic [$clog2(DEPTH):0]   o_occupancy,
    output logic                     o_overflow_detected,
    output logic [1:0]               o_rx_state
);
    localparam int W  = NBYTES * 8;

    rx_state_e state_r;
    rx_state_e state_nxt_s;
    logic      valid_s;
    logic      push_req_s;
    logic      push_s;
    logic      pop_s;
    logic      overflow_s;
    logic      full_s;
    logic      empty_s;
    logic      credit_r;
    logic      overflow_r;

    ucie_ctl_rx_fifo #(
        .WIDTH (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (i_clk),
        .rst     (i_rst),
        .push    (push_s),
        .pop     (pop_s),
        .flush   (overflow_s),
        .wr_data (i_rdi_pl_data),
        .rd_data (o_fdi_data),
        .count   (o_occupancy),
        .full    (full_s),
        .empty   (empty_s)
    );

    assign o_fdi_data_valid    = valid_s;
    assign o_credit_return     = credit_r;
    assign o_overflow_detected = overflow_r;
    assign o_rx_state          = state_r;

    // Datapath handshakes: the consumer only sees data in ACTIVE/DRAIN,
    // and a push onto a full FIFO with no pop is an overrun.
    always_comb begin
        valid_s    = 1'b0;
        push_req_s = 1'b0;
        if (!empty_s && ((state_r == ST_ACTIVE) || (state_r == ST_DRAIN))) begin
            valid_s = 1'b1;
        end else begin
            valid_s = 1'b0;
        end
        if (state_r == ST_ACTIVE) begin
            push_req_s = i_rdi_pl_valid;
        end else begin
            push_req_s = 1'b0;
        end
        pop_s      = valid_s && i_fdi_ready;
        overflow_s = push_req_s && full_s && !pop_s;
        push_s     = push_req_s && !overflow_s;
    end

    // Next-state logic; an overrun beats any concurrent request.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RESET: begin
                if (i_state_request == REQ_ACTIVE) begin
                    state_nxt_s = ST_ACTIVE;
                end else begin
                    state_nxt_s = ST_RESET;
                end
            end
            ST_ACTIVE: begin
                if (overflow_s) begin
                    state_nxt_s = ST_ERROR;
                end else if (is_exit_req(i_state_request)) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_ACTIVE;
                end
            end
            ST_DRAIN: begin
                if (i_state_request == REQ_ACTIVE) begin
                    state_nxt_s = ST_ACTIVE;
                end else if (empty_s) begin
                    state_nxt_s = ST_RESET;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_ERROR: begin
                if (i_state_request == REQ_LINKRESET) begin
                    state_nxt_s = ST_RESET;
                end else begin
                    state_nxt_s = ST_ERROR;
                end
            end
            default: state_nxt_s = ST_RESET;
        endcase
    end

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= ST_RESET;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Credit pulse one cycle after each pop; sticky overrun flag cleared on ERROR exit.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            credit_r   <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            credit_r <= pop_s;
            if (overflow_s) begin
                overflow_r <= 1'b1;
            end else if ((state_r == ST_ERROR) && (state_nxt_s == ST_RESET)) begin
                overflow_r <= 1'b0;
            end else begin
                overflow_r <= overflow_r;
            end
        end
    end

endmodule

// File: tb/tb_ucie_ctl_rx_credit_buffer.sv
// Self-checking bench for ucie_ctl_rx_credit_buffer: directed scenarios plus a
// randomized run compared cycle by cycle against a queue-based reference model.
module tb_ucie_ctl_rx_credit_buffer;

    localparam int NBYTES = 8;
    localparam int DEPTH  = 8;
    localparam int W      = NBYTES * 8;
    localparam int CW     = $clog2(DEPTH) + 1;

    localparam logic [3:0] R_NOP = 4'b0000;
    localparam logic [3:0] R_ACT = 4'b0001;
    localparam logic [3:0] R_L1  = 4'b0100;
    localparam logic [3:0] R_L2  = 4'b1000;
    localparam logic [3:0] R_LR  = 4'b1001;
    localparam logic [3:0] R_RT  = 4'b1011;
    localparam logic [3:0] R_DIS = 4'b1100;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [3:0]    state_request = 4'b0000;
    logic [W-1:0]  rdi_data = '0;
    logic          rdi_valid = 1'b0;
    logic          fdi_ready = 1'b0;
    logic [W-1:0]  fdi_data;
    logic          fdi_valid;
    logic          credit_return;
    logic [CW-1:0] occupancy;
    logic          overflow;
    logic [1:0]    rx_state;

    int checks = 0;
    int errors = 0;
    int credit_cnt = 0;
    logic [W-1:0] obs_q[$];

    // Reference model: list of stored flits plus link state (0 reset, 1 active, 2 drain, 3 error).
    logic [W-1:0] m_q[$];
    int           m_state = 0;
    logic         m_ovf = 1'b0;
    logic         m_credit = 1'b0;

    ucie_ctl_rx_credit_buffer #(.NBYTES(NBYTES), .DEPTH(DEPTH)) dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_state_request     (state_request),
        .i_rdi_pl_data       (rdi_data),
        .i_rdi_pl_valid      (rdi_valid),
        .i_fdi_ready         (fdi_ready),
        .o_fdi_data          (fdi_data),
        .o_fdi_data_valid    (fdi_valid),
        .o_credit_return     (credit_return),
        .o_occupancy         (occupancy),
        .o_overflow_detected (overflow),
        .o_rx_state          (rx_state)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] rand_flit();
        logic [W-1:0] f;
        f = {$urandom(), $urandom()};
        return f;
    endfunction

    function automatic void model_step(input logic [3:0] req, input logic v,
                                       input logic [W-1:0] d, input logic rdy,
                                       input logic r);
        bit vld, pop, push, ovf, exit_req;
        int ns;
        if (r) begin
            m_q.delete();
            m_state  = 0;
            m_ovf    = 1'b0;
            m_credit = 1'b0;
            return;
        end
        vld      = (m_q.size() > 0) && (m_state == 1 || m_state == 2);
        pop      = vld && rdy;
        push     = (m_state == 1) && v;
        ovf      = push && (m_q.size() == DEPTH) && !pop;
        exit_req = (req == R_L1) || (req == R_L2) || (req == R_LR) ||
                   (req == R_RT) || (req == R_DIS);
        ns = m_state;
        if (m_state == 0 && req == R_ACT) ns = 1;
        if (m_state == 1) ns = ovf ? 3 : (exit_req ? 2 : 1);
        if (m_state == 2) ns = (req == R_ACT) ? 1 : ((m_q.size() == 0) ? 0 : 2);
        if (m_state == 3 && req == R_LR) ns = 0;
        m_credit = pop;
        if (pop) void'(m_q.pop_front());
        if (push && !ovf) m_q.push_back(d);
        if (ovf) begin
            m_q.delete();
            m_ovf = 1'b1;
        end
        if (m_state == 3 && ns == 0) m_ovf = 1'b0;
        m_state = ns;
    endfunction

    // One clock: drive inputs, note any pop, advance model and DUT, tally credits.
    task automatic cycle(input logic [3:0] req, input logic v, input logic [W-1:0] d,
                         input logic rdy, input logic r);
        state_request = req;
        rdi_valid     = v;
        rdi_data      = d;
        fdi_ready     = rdy;
        rst           = r;
        #1;
        if (!r && fdi_valid && rdy) obs_q.push_back(fdi_data);
        model_step(req, v, d, rdy, r);
        @(posedge clk);
        #1;
        credit_cnt = credit_cnt + int'(credit_return);
    endtask

    task automatic start_active();
        cycle(R_NOP, 1'b0, '0, 1'b0, 1'b1);
        cycle(R_ACT, 1'b0, '0, 1'b0, 1'b0);
        obs_q.delete();
        credit_cnt = 0;
    endtask

    task automatic test_reset();
        cycle(R_ACT, 1'b1, rand_flit(), 1'b1, 1'b1);
        cycle(R_NOP, 1'b0, '0, 1'b0, 1'b1);
        checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL reset_occ got %0d exp 0", occupancy); end
        checks++; if (fdi_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", fdi_valid); end
        checks++; if (rx_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", rx_state); end
        checks++; if (credit_return !== 1'b0) begin errors++; $display("FAIL reset_credit got %b exp 0", credit_return); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", overflow); end
    endtask

    task automatic test_basic();
        logic [W-1:0] f[3];
        start_active();
        checks++; if (rx_state !== 2'd1) begin errors++; $display("FAIL basic_active got %0d exp 1", rx_state); end
        for (int i = 0; i < 3; i++) begin
            f[i] = rand_flit();
            cycle(R_NOP, 1'b1, f[i], 1'b1, 1'b0);
            checks++;
            if (fdi_valid !== 1'b1 || fdi_data !== f[i]) begin
                errors++; $display("FAIL basic_fwft%0d got v=%b %h exp v=1 %h", i, fdi_valid, fdi_data, f[i]);
            end
        end
        cycle(R_NOP, 1'b0, '0, 1'b1, 1'b0);
        cycle(R_NOP, 1'b0, '0, 1'b1, 1'b0);
        checks++; if (credit_cnt != 3) begin errors++; $display("FAIL basic_credits got %0d exp 3", credit_cnt); end
        checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL basic_occ got %0d exp 0", occupancy); end
        checks++;
        if (obs_q.size() != 3 || obs_q[0] !== f[0] || obs_q[1] !== f[1] || obs_q[2] !== f[2]) begin
            errors++; $display("FAIL basic_order got %0d flits exp 3 in order", obs_q.size());
        end
    endtask

    task automatic test_full_push_pop();
        logic [W-1:0] f[DEPTH];
        start_active();
        for (int i = 0; i < DEPTH; i++) begin
            f[i] = rand_flit();
            cycle(R_NOP, 1'b1, f[i], 1'b0, 1'b0);
        end
        checks++; if (occupancy !== 4'd8) begin errors++; $display("FAIL full_occ got %0d exp 8", occupancy); end
        cycle(R_NOP, 1'b1, rand_flit(), 1'b1, 1'b0);
        checks++; if (occupancy !== 4'd8) begin errors++; $display("FAIL full_pushpop_occ got %0d exp 8", occupancy); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_pushpop_ovf got %b exp 0", overflow); end
        checks++; if (fdi_data !== f[1]) begin errors++; $display("FAIL full_pushpop_head got %h exp %h", fdi_data, f[1]); end
        checks++; if (rx_state !== 2'd1) begin errors++; $display("FAIL full_pushpop_state got %0d exp 1", rx_state); end
    endtask

    task automatic test_overflow();
        start_active();
        for (int i = 0; i < DEPTH; i++) cycle(R_NOP, 1'b1, rand_flit(), 1'b0, 1'b0);
        credit_cnt = 0;
        cycle(R_NOP, 1'b1, rand_flit(), 1'b0, 1'b0);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", overflow); end
        checks++; if (rx_state !== 2'd3) begin errors++; $display("FAIL ovf_state got %0d exp 3", rx_state); end
        checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL ovf_occ got %0d exp 0", occupancy); end
        checks++; if (fdi_valid !== 1'b0) begin errors++; $display("FAIL ovf_valid got %b exp 0", fdi_valid); end
        cycle(R_ACT, 1'b1, rand_flit(), 1'b1, 1'b0);
        checks++; if (rx_state !== 2'd3 || overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got st=%0d ovf=%b exp st=3 ovf=1", rx_state, overflow); end
        checks++; if (credit_cnt != 0) begin errors++; $display("FAIL ovf_credits got %0d exp 0", credit_cnt); end
        cycle(R_LR, 1'b0, '0, 1'b0, 1'b0);
        checks++; if (rx_state !== 2'd0) begin errors++; $display("FAIL ovf_lr_state got %0d exp 0", rx_state); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_lr_flag got %b exp 0", overflow); end
    endtask

    task automatic test_drain();
        logic [W-1:0] f[4];
        start_active();
        for (int i = 0; i < 4; i++) begin
            f[i] = rand_flit();
            cycle(R_NOP, 1'b1, f[i], 1'b0, 1'b0);
        end
        cycle(R_L1, 1'b0, '0, 1'b0, 1'b0);
        checks++; if (rx_state !== 2'd2) begin errors++; $display("FAIL drain_state got %0d exp 2", rx_state); end
        for (int i = 0; i < 8; i++) begin
            cycle(R_NOP, 1'b1, rand_flit(), 1'b1, 1'b0);
            checks++;
            if (int'(occupancy) != ((i < 3) ? 3 - i : 0)) begin
                errors++; $display("FAIL drain_occ%0d got %0d exp %0d", i, occupancy, (i < 3) ? 3 - i : 0);
            end
        end
        checks++; if (credit_cnt != 4) begin errors++; $display("FAIL drain_credits got %0d exp 4", credit_cnt); end
        checks++; if (rx_state !== 2'd0) begin errors++; $display("FAIL drain_end_state got %0d exp 0", rx_state); end
        checks++;
        if (obs_q.size() != 4 || obs_q[0] !== f[0] || obs_q[1] !== f[1] || obs_q[2] !== f[2] || obs_q[3] !== f[3]) begin
            errors++; $display("FAIL drain_order got %0d flits exp 4 in order", obs_q.size());
        end
    endtask

    task automatic test_reset_mid();
        start_active();
        for (int i = 0; i < 5; i++) cycle(R_NOP, 1'b1, rand_flit(), 1'b0, 1'b0);
        checks++; if (occupancy !== 4'd5) begin errors++; $display("FAIL rstmid_pre_occ got %0d exp 5", occupancy); end
        cycle(R_NOP, 1'b0, '0, 1'b1, 1'b1);
        checks++;
        if (occupancy !== 4'd0 || fdi_valid !== 1'b0 || rx_state !== 2'd0) begin
            errors++; $display("FAIL rstmid_state got occ=%0d v=%b st=%0d exp 0 0 0", occupancy, fdi_valid, rx_state);
        end
        cycle(R_NOP, 1'b0, '0, 1'b1, 1'b0);
        cycle(R_NOP, 1'b0, '0, 1'b1, 1'b0);
        checks++; if (credit_cnt != 0) begin errors++; $display("FAIL rstmid_credits got %0d exp 0", credit_cnt); end
    endtask

    task automatic test_ready_toggle();
        logic [W-1:0] f[6];
        logic         prev_v;
        logic [W-1:0] prev_d;
        logic         rdy;
        start_active();
        for (int i = 0; i < 6; i++) f[i] = rand_flit();
        for (int i = 0; i < 16; i++) begin
            prev_v = fdi_valid;
            prev_d = fdi_data;
            rdy    = (i % 2 == 0);
            cycle(R_NOP, (i < 6), (i < 6) ? f[i] : '0, rdy, 1'b0);
            if (prev_v && !rdy) begin
                checks++;
                if (fdi_valid !== 1'b1 || fdi_data !== prev_d) begin
                    errors++; $display("FAIL toggle_hold%0d got v=%b %h exp v=1 %h", i, fdi_valid, fdi_data, prev_d);
                end
            end
        end
        checks++; if (obs_q.size() != 6) begin errors++; $display("FAIL toggle_count got %0d exp 6", obs_q.size()); end
        for (int i = 0; i < 6; i++) begin
            if (i < obs_q.size()) begin
                checks++;
                if (obs_q[i] !== f[i]) begin errors++; $display("FAIL toggle_flit%0d got %h exp %h", i, obs_q[i], f[i]); end
            end
        end
        checks++; if (credit_cnt != 6) begin errors++; $display("FAIL toggle_credits got %0d exp 6", credit_cnt); end
    endtask

    task automatic test_random();
        logic [3:0] exits[5];
        logic [3:0] req;
        int         r;
        exits[0] = R_L1; exits[1] = R_L2; exits[2] = R_LR; exits[3] = R_RT; exits[4] = R_DIS;
        cycle(R_NOP, 1'b0, '0, 1'b0, 1'b1);
        for (int n = 0; n < 400; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 70)      req = R_NOP;
            else if (r < 82) req = R_ACT;
            else if (r < 88) req = exits[$urandom_range(0, 4)];
            else if (r < 92) req = R_LR;
            else             req = 4'($urandom_range(0, 15));
            cycle(req, ($urandom_range(0, 99) < 60), rand_flit(),
                  ($urandom_range(0, 99) < 50), ($urandom_range(0, 99) < 2));
            checks++;
            if (int'(rx_state) != m_state || int'(occupancy) != m_q.size() ||
                credit_return !== m_credit || overflow !== m_ovf) begin
                errors++;
                $display("FAIL rand%0d got st=%0d occ=%0d cr=%b ovf=%b exp st=%0d occ=%0d cr=%b ovf=%b",
                         n, rx_state, occupancy, credit_return, overflow, m_state, m_q.size(), m_credit, m_ovf);
            end
            checks++;
            if (fdi_valid !== ((m_q.size() > 0) && (m_state == 1 || m_state == 2))) begin
                errors++; $display("FAIL rand_valid%0d got %b exp %b", n, fdi_valid, !fdi_valid);
            end else if (fdi_valid && fdi_data !== m_q[0]) begin
                errors++; $display("FAIL rand_data%0d got %h exp %h", n, fdi_data, m_q[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_push_pop();
        test_overflow();
        test_drain();
        test_reset_mid();
        test_ready_toggle();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ucie_ctl_rx_credit_buffer.md
UCIE_CTL_RX_CREDIT_BUFFER -- requirements
Module: ucie_ctl_rx_credit_buffer

Interface
REQ-001 The block SHALL have parameter NBYTES, default 64, meaning the flit width in bytes (data width NBYTES*8).
REQ-002 The block SHALL have parameter DEPTH, default 8, meaning the FIFO entry count; it is a power of two and at least 2.
REQ-003 The block SHALL have port i_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port i_state_request, input, 4 bits: link state request.
REQ-006 The block SHALL have port i_rdi_pl_data, input, NBYTES*8 bits: received flit.
REQ-007 The block SHALL have port i_rdi_pl_valid, input, 1 bit: i_rdi_pl_data is valid this cycle; it has no backpressure.
REQ-008 The block SHALL have port i_fdi_ready, input, 1 bit: the consumer accepts o_fdi_data.
REQ-009 The block SHALL have port o_fdi_data, output, NBYTES*8 bits: head-of-FIFO flit.
REQ-010 The block SHALL have port o_fdi_data_valid, output, 1 bit: o_fdi_data is valid.
REQ-011 The block SHALL have port o_credit_return, output, 1 bit: one-cycle pulse per freed entry.
REQ-012 The block SHALL have port o_occupancy, output, $clog2(DEPTH)+1 bits: number of stored entries.
REQ-013 The block SHALL have port o_overflow_detected, output, 1 bit: sticky overflow flag.
REQ-014 The block SHALL have port o_rx_state, output, 2 bits: current FSM state.

Function
REQ-015 The FSM SHALL use states RESET=0, ACTIVE=1, DRAIN=2 and ERROR=3.
REQ-016 Request encodings SHALL be NOP=0000, ACTIVE=0001, L1=0100, L2=1000, LINKRESET=1001, RETRAIN=1011, DISABLED=1100; any other value is treated as NOP.
REQ-017 The FSM SHALL transition RESET->ACTIVE when the request is ACTIVE.
REQ-018 The FSM SHALL transition ACTIVE->DRAIN on a request of L1, L2, LINKRESET, RETRAIN or DISABLED.
REQ-019 The FSM SHALL transition DRAIN->ACTIVE when the request is ACTIVE.
REQ-020 The FSM SHALL transition DRAIN->RESET when the FIFO is empty and the request is not ACTIVE.
REQ-021 The FSM SHALL transition ACTIVE->ERROR on overflow; overflow takes priority over any request.
REQ-022 The FSM SHALL transition ERROR->RESET only when the request is LINKRESET.
REQ-023 A push SHALL occur only in ACTIVE with i_rdi_pl_valid=1; valid flits in RESET, DRAIN or ERROR SHALL be dropped without flagging.
REQ-024 The FIFO SHALL be first-word-fall-through: a flit pushed at edge N is visible on o_fdi_data at N+1 when the FIFO was empty.
REQ-025 o_fdi_data_valid SHALL equal (not empty) AND (state is ACTIVE or DRAIN).
REQ-026 A pop SHALL occur on o_fdi_data_valid AND i_fdi_ready.
REQ-027 o_fdi_data SHALL remain stable while valid=1 and ready=0.
REQ-028 Overflow SHALL be a push while full without a simultaneous pop; the flit is discarded, o_overflow_detected sets at the next edge, and the state enters ERROR.
REQ-029 A simultaneous push and pop while full SHALL be legal: occupancy stays DEPTH and no overflow is flagged.
REQ-030 A simultaneous push and pop while empty SHALL be impossible: valid=0 when empty, so only the push takes effect.
REQ-031 Pointers SHALL wrap modulo DEPTH; occupancy SHALL range from 0 to DEPTH inclusive.
REQ-032 o_credit_return SHALL be registered, high exactly one cycle after each pop.
REQ-033 Entering ERROR SHALL flush the FIFO (occupancy to 0) without asserting o_credit_return.
REQ-034 o_overflow_detected SHALL clear only on the ERROR->RESET transition or on reset.

Reset
REQ-035 On i_rst=1 at a rising edge: state=RESET, pointers=0, occupancy=0, o_fdi_data_valid=0, o_credit_return=0, o_overflow_detected=0.
REQ-036 Reset mid-operation SHALL discard all stored flits with no credit pulses.
REQ-037 FIFO storage array contents SHALL not be reset; o_fdi_data is don't-care while valid=0.

Structure
REQ-038 Package ucie_ctl_rx_pkg SHALL hold the state-request encoding constants and the 2-bit FSM state type.
REQ-039 Sub-module ucie_ctl_rx_fifo SHALL hold storage, pointers, occupancy and full/empty, with push, pop and flush controls.
REQ-040 The top level SHALL hold the FSM, overflow detection, and credit pulse generation.

Verification
REQ-041 Reset, request ACTIVE, push 3 flits A,B,C with ready=1 -> A,B,C appear in order, each one cycle after its push, 3 credit pulses, occupancy returns to 0.
REQ-042 DEPTH=8, ready=0, push 8 flits, then push plus pop in the same cycle -> occupancy stays 8 and overflow stays 0.
REQ-043 Full FIFO, push with ready=0 -> overflow=1 next cycle, state=ERROR, occupancy=0, no credit pulse; request LINKRESET -> state=RESET, overflow=0.
REQ-044 4 entries stored, request L1 -> state=DRAIN, incoming valid flits dropped, 4 pops with 4 credits, then state=RESET.
REQ-045 i_rst asserted with 5 entries stored -> next cycle occupancy=0, valid=0, state=RESET, no credits.
REQ-046 ready toggling 1010 over a stream of 6 flits -> o_fdi_data holds while ready=0 and no flit is lost or duplicated.
